mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Bus initiator for the development memory system: accepts byte/word read and write requests from a core-side valid/ready port and drives the shared address, data and read_write_sel bus that the memory responder serves.
- Sequences the tristate data bus safely, handles memory read latency plus configurable wait states, and returns one response pulse per request.
- Word accesses (e.g. vector fetch) are two little-endian byte cycles.

Parameters:
- WAIT_STATES, 0, extra ph2 cycles inserted before each read-data capture.
- PARK_ADDR, 16'hFFFF, address driven during write turnaround; must be outside RAM (0x0000-0x0FFF) so the responder ignores writes there.

Ports:
- ph2  input  1  sole clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (IDLE only).
- req_write  input  1  1 = write, 0 = read.
- req_word  input  1  1 = 16-bit access, 0 = byte.
- req_addr  input  16  byte address (low byte of a word).
- req_wdata  input  16  write data; [7:0] to addr, [15:8] to addr+1.
- rsp_valid  output  1  one-cycle completion pulse, no back-pressure.
- rsp_rdata  output  16  read data; byte read zero-extends; 0 for writes.
- address  output  16  memory bus address.
- data  inout  8  memory bus data; driven only while write-enabled.
- read_write_sel  output  1  1 = read, 0 = write.

Behaviour:
- All outputs registered. Reset (async assert): state IDLE, address=PARK_ADDR, read_write_sel=1, data released (z), rsp_valid=0, rsp_rdata=0, req_ready=1 after the first edge following deassertion.
- Handshake: request accepted at a posedge where req_valid && req_ready. Request fields are latched at that edge; inputs may then change.
- States: IDLE, TURN, WRITE, RADDR, RWAIT.
- IDLE: read_write_sel=1, data z, address held. On accept with req_write=1, go to TURN; with req_write=0, go to RADDR.
- TURN (1 cycle): address=PARK_ADDR, read_write_sel=0, data z. The responder releases the bus while no RAM write can occur. Then go to WRITE.
- WRITE (1 cycle per byte): address=target, read_write_sel=0, data driven with the byte; the responder writes at the closing edge.
  - Word: the low byte goes to addr, then the high byte to addr+1 in the next cycle, with no turnaround between.
  - After the last byte, go to IDLE with read_write_sel=1 and data z set at the same edge.
- RADDR: address=target, read_write_sel=1. The responder latches at the closing edge. Then go to RWAIT.
- RWAIT: lasts 1+WAIT_STATES cycles. The byte on data is captured at the final edge.
  - Word: a second RADDR/RWAIT pass at addr+1 fills rsp_rdata[15:8].
- Latency, accept edge to rsp_valid high:
  - byte read: 2+WAIT_STATES edges.
  - word read: 2*(2+WAIT_STATES).
  - byte write: 2.
  - word write: 3.
- rsp_valid is high for exactly one cycle, coinciding with re-entry to IDLE. A new request may be accepted in that same cycle.
- Address wrap: addr+1 is computed mod 2^16, so a word at 0xFFFF uses 0xFFFF then 0x0000.
- Reset mid-operation aborts immediately: bus released, read_write_sel=1, no response. A word write may have completed its low byte only.
- read_write_sel is never 0 while state is IDLE, RADDR or RWAIT. data is never driven outside WRITE.

Decomposition:
- mem_pkg holds:
  - the state enum (IDLE, TURN, WRITE, RADDR, RWAIT),
  - RAM_BASE 16'h0000, RAM_TOP 16'h0FFF, ROM_BASE 16'hF000 region constants,
  - the default PARK_ADDR.
- One natural sub-module: wait_counter (load value, decrement, done flag), used for RWAIT.

Test Plan:
- Byte write 0xA5 to 0x0010, then byte read 0x0010 with WAIT_STATES=0 -> write rsp_valid 2 edges after accept, read rsp_rdata=16'h00A5 2 edges after accept; bus never X during TURN.
- Word write 16'hBEEF to 0x0100, word read 0x0100 -> RAM[0x100]=0xEF, RAM[0x101]=0xBE, rsp_rdata=16'hBEEF after 4 edges.
- Word read at 0xFFFC with ROM preloaded 0x00,0xF0 -> rsp_rdata=16'hF000 (reset-vector style); word read at 0xFFFF returns {RAM[0x0000], ROM[0xFFF]}.
- WAIT_STATES=2, byte read -> rsp_valid exactly 4 edges after accept; back-to-back requests with req_valid held accepted on the rsp_valid cycle.
- Reset low during the second byte of a word write to 0x0200 -> read_write_sel=1 and data z immediately, no rsp_valid, RAM[0x201] unchanged, req_ready=1 after release.
- Write to 0x2000 (unmapped) then read it -> no RAM change, rsp_rdata=16'h0000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and memory-map constants for the development memory bus initiator.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TURN  = 3'd1,
    WRITE = 3'd2,
    RADDR = 3'd3,
    RWAIT = 3'd4
  } state_t;

  localparam logic [15:0] RAM_BASE          = 16'h0000;
  localparam logic [15:0] RAM_TOP           = 16'h0FFF;
  localparam logic [15:0] ROM_BASE          = 16'hF000;
  localparam logic [15:0] PARK_ADDR_DEFAULT = 16'hFFFF;

  function automatic logic in_ram(input logic [15:0] a);
    return a <= RAM_TOP;
  endfunction

endpackage

// File: rtl/mem_master_wait_counter.sv
// Read wait-state counter: loads a count, decrements while enabled, flags zero.
// done is combinational from the count so the FSM can leave RWAIT on the final edge.
module mem_master_wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_master.sv
// Memory bus initiator: byte/word requests in, registered address/data/read_write_sel out.
// Latency: byte read 2+WS, word read 2*(2+WS), byte write 2, word write 3; ready only in IDLE.
module mem_master
  import mem_pkg::*;
#(
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] PARK_ADDR   = PARK_ADDR_DEFAULT
) (
  input  logic        ph2,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [15:0] address,
  inout  wire  [7:0]  data,
  output logic        read_write_sel
);

  localparam int WC_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_t      state, state_n;
  logic [15:0] tgt_q, tgt_n;
  logic [15:0] wdata_q, wdata_n;
  logic        word_q, word_n;
  logic        hi_q, hi_n;
  logic [7:0]  lo_q, lo_n;
  logic        drive_q, drive_n;
  logic [7:0]  wbyte_q, wbyte_n;
  logic [15:0] address_n;
  logic        rw_n;
  logic        rsp_valid_n;
  logic [15:0] rsp_rdata_n;
  logic        wc_load, wc_dec, wc_done;

  mem_master_wait_counter #(.WIDTH(WC_W)) u_wait (
    .clk      (ph2),
    .rst_n    (reset),
    .load     (wc_load),
    .load_val (WC_W'(WAIT_STATES)),
    .dec      (wc_dec),
    .done     (wc_done)
  );

  // Only WRITE ever enables the driver; it switches off on the same edge rw returns to 1.
  assign data = drive_q ? wbyte_q : 8'hzz;

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      address        <= PARK_ADDR;
      read_write_sel <= 1'b1;
      drive_q        <= 1'b0;
      wbyte_q        <= 8'h00;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= 16'h0000;
      req_ready      <= 1'b0;
      tgt_q          <= 16'h0000;
      wdata_q        <= 16'h0000;
      word_q         <= 1'b0;
      hi_q           <= 1'b0;
      lo_q           <= 8'h00;
    end else begin
      state          <= state_n;
      address        <= address_n;
      read_write_sel <= rw_n;
      drive_q        <= drive_n;
      wbyte_q        <= wbyte_n;
      rsp_valid      <= rsp_valid_n;
      rsp_rdata      <= rsp_rdata_n;
      req_ready      <= (state_n == IDLE);
      tgt_q          <= tgt_n;
      wdata_q        <= wdata_n;
      word_q         <= word_n;
      hi_q           <= hi_n;
      lo_q           <= lo_n;
    end
  end

  always_comb begin
    state_n     = state;
    address_n   = address;
    rw_n        = 1'b1;
    drive_n     = 1'b0;
    wbyte_n     = wbyte_q;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    tgt_n       = tgt_q;
    wdata_n     = wdata_q;
    word_n      = word_q;
    hi_n        = hi_q;
    lo_n        = lo_q;
    wc_load     = 1'b0;
    wc_dec      = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          tgt_n   = req_addr;
          wdata_n = req_wdata;
          word_n  = req_word;
          hi_n    = 1'b0;
          if (req_write) begin
            // Park outside RAM while the responder releases the bus.
            state_n   = TURN;
            address_n = PARK_ADDR;
            rw_n      = 1'b0;
          end else begin
            state_n   = RADDR;
            address_n = req_addr;
          end
        end
      end
      TURN: begin
        state_n   = WRITE;
        address_n = tgt_q;
        rw_n      = 1'b0;
        drive_n   = 1'b1;
        wbyte_n   = wdata_q[7:0];
      end
      WRITE: begin
        if (word_q && !hi_q) begin
          hi_n      = 1'b1;
          address_n = tgt_q + 16'd1;
          rw_n      = 1'b0;
          drive_n   = 1'b1;
          wbyte_n   = wdata_q[15:8];
        end else begin
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = 16'h0000;
        end
      end
      RADDR: begin
        state_n = RWAIT;
        wc_load = 1'b1;
      end
      RWAIT: begin
        if (!wc_done) begin
          wc_dec = 1'b1;
        end else if (word_q && !hi_q) begin
          lo_n      = data;
          hi_n      = 1'b1;
          state_n   = RADDR;
          address_n = tgt_q + 16'd1;
        end else begin
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = word_q ? {data, lo_q} : {8'h00, data};
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: two instances (WAIT_STATES 0 and 2), each on its own RAM/ROM responder.
module tb_mem_master;
  import mem_pkg::*;

  logic ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  logic [1:0]  rst, req_valid, req_ready, req_write, req_word, rsp_valid, rws;
  logic [15:0] req_addr [2];
  logic [15:0] req_wdata [2];
  logic [15:0] rsp_rdata [2];
  logic [15:0] address [2];
  logic [15:0] lat_addr [2];
  wire  [7:0]  bus0, bus1;
  logic [7:0]  rd0, rd1;
  logic        mem_clear;

  logic [7:0] ram  [2][4096];
  logic [7:0] mref [2][4096];
  logic [7:0] rom  [4096];

  int checks = 0;
  int failures = 0;

  mem_master #(.WAIT_STATES(0)) dut0 (
    .ph2(ph2), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_word(req_word[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .address(address[0]), .data(bus0), .read_write_sel(rws[0]));

  mem_master #(.WAIT_STATES(2)) dut1 (
    .ph2(ph2), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_word(req_word[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .address(address[1]), .data(bus1), .read_write_sel(rws[1]));

  // Responder: drives the byte at the latched address whenever read_write_sel is high.
  assign bus0 = rws[0] ? rd0 : 8'hzz;
  assign bus1 = rws[1] ? rd1 : 8'hzz;

  always_comb begin
    rd0 = 8'h00;
    if (lat_addr[0] <= RAM_TOP) rd0 = ram[0][lat_addr[0][11:0]];
    else if (lat_addr[0] >= ROM_BASE) rd0 = rom[lat_addr[0][11:0]];
  end

  always_comb begin
    rd1 = 8'h00;
    if (lat_addr[1] <= RAM_TOP) rd1 = ram[1][lat_addr[1][11:0]];
    else if (lat_addr[1] >= ROM_BASE) rd1 = rom[lat_addr[1][11:0]];
  end

  always @(posedge ph2) begin
    if (mem_clear) begin
      for (int j = 0; j < 4096; j++) begin
        ram[0][j] <= 8'h00;
        ram[1][j] <= 8'h00;
      end
    end else begin
      if (!rws[0] && in_ram(address[0])) ram[0][address[0][11:0]] <= bus0;
      if (!rws[1] && in_ram(address[1])) ram[1][address[1][11:0]] <= bus1;
    end
    if (rws[0]) lat_addr[0] <= address[0];
    if (rws[1]) lat_addr[1] <= address[1];
  end

  function automatic logic [7:0] busv(input int i);
    return (i == 0) ? bus0 : bus1;
  endfunction

  function automatic logic [7:0] mread(input int i, input logic [15:0] a);
    if (in_ram(a)) return mref[i][a[11:0]];
    if (a >= ROM_BASE) return rom[a[11:0]];
    return 8'h00;
  endfunction

  // Applies a request to the reference memory and returns the expected response data.
  function automatic logic [15:0] model_op(input int i, input bit w, input bit wd,
                                           input logic [15:0] a, input logic [15:0] d);
    logic [15:0] a1;
    a1 = a + 16'd1;
    if (w) begin
      if (in_ram(a)) mref[i][a[11:0]] = d[7:0];
      if (wd && in_ram(a1)) mref[i][a1[11:0]] = d[15:8];
      return 16'h0000;
    end
    if (wd) return {mread(i, a1), mread(i, a)};
    return {8'h00, mread(i, a)};
  endfunction

  function automatic int exp_lat(input int ws, input bit w, input bit wd);
    if (w) return wd ? 3 : 2;
    return wd ? 2 * (2 + ws) : 2 + ws;
  endfunction

  // Presents one request, waits for its response, and records whether the bus
  // sequence (park, low byte, high byte) and ready/read_write_sel behaviour held.
  task automatic issue(input int i, input bit w, input bit wd, input logic [15:0] a,
                       input logic [15:0] d, input bit keep,
                       output int lat, output logic [15:0] rdat, output bit tok);
    int nwr;
    logic [15:0] a1;
    a1 = a + 16'd1;
    nwr = 0;
    tok = 1'b1;
    req_write[i] = w; req_word[i] = wd; req_addr[i] = a; req_wdata[i] = d;
    req_valid[i] = 1'b1;
    @(posedge ph2); #1;
    if (!keep) req_valid[i] = 1'b0;
    if (req_ready[i] !== 1'b0) tok = 1'b0;
    lat = 0;
    while (rsp_valid[i] !== 1'b1 && lat < 40) begin
      if (rws[i] === 1'b0) begin
        if (!w) tok = 1'b0;
        else if (nwr == 0 && address[i] !== 16'hFFFF) tok = 1'b0;
        else if (nwr == 1 && (address[i] !== a || busv(i) !== d[7:0])) tok = 1'b0;
        else if (nwr == 2 && (address[i] !== a1 || busv(i) !== d[15:8])) tok = 1'b0;
        nwr++;
      end
      @(posedge ph2); #1;
      lat++;
    end
    if (nwr != (w ? (wd ? 3 : 2) : 0)) tok = 1'b0;
    rdat = rsp_rdata[i];
  endtask

  task automatic test_reset();
    rst = 2'b00; mem_clear = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; req_word = 2'b00;
    for (int i = 0; i < 2; i++) begin req_addr[i] = 16'h0; req_wdata[i] = 16'h0; end
    repeat (3) @(posedge ph2);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (address[i] !== 16'hFFFF) begin failures++; $display("FAIL rst_addr[%0d] got=%h exp=ffff", i, address[i]); end
      checks++; if (rws[i] !== 1'b1) begin failures++; $display("FAIL rst_rws[%0d] got=%b exp=1", i, rws[i]); end
      checks++; if ({rsp_valid[i], rsp_rdata[i]} !== 17'h0) begin failures++; $display("FAIL rst_rsp[%0d] got=%b/%h exp=0/0000", i, rsp_valid[i], rsp_rdata[i]); end
      checks++; if (req_ready[i] !== 1'b0) begin failures++; $display("FAIL rst_ready[%0d] got=%b exp=0", i, req_ready[i]); end
    end
    @(negedge ph2); mem_clear = 1'b0; rst = 2'b11;
    @(posedge ph2); #1;
    checks++; if (req_ready !== 2'b11) begin failures++; $display("FAIL rst_ready_after got=%b exp=11", req_ready); end
  endtask

  task automatic test_byte_wr_rd();
    int lat; logic [15:0] rd, ex; bit tok;
    issue(0, 1'b1, 1'b0, 16'h0010, 16'h00A5, 1'b0, lat, rd, tok);
    ex = model_op(0, 1'b1, 1'b0, 16'h0010, 16'h00A5);
    checks++; if (lat != 2) begin failures++; $display("FAIL bwr_lat got=%0d exp=2", lat); end
    checks++; if ({rd, tok} !== {ex, 1'b1}) begin failures++; $display("FAIL bwr_rsp got=%h/%b exp=%h/1", rd, tok, ex); end
    checks++; if (ram[0][16] !== 8'hA5) begin failures++; $display("FAIL bwr_ram got=%h exp=a5", ram[0][16]); end
    issue(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, rd, tok);
    ex = model_op(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    checks++; if (lat != 2) begin failures++; $display("FAIL brd_lat got=%0d exp=2", lat); end
    checks++; if ({rd, tok} !== {16'h00A5, 1'b1} || ex !== 16'h00A5) begin failures++; $display("FAIL brd_data got=%h/%b exp=00a5/1", rd, tok); end
    @(posedge ph2); #1;
    checks++; if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin failures++; $display("FAIL rsp_pulse got=%b/%b exp=0/1", rsp_valid[0], req_ready[0]); end
  endtask

  task automatic test_word();
    int lat; logic [15:0] rd, ex; bit tok;
    issue(0, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, lat, rd, tok);
    ex = model_op(0, 1'b1, 1'b1, 16'h0100, 16'hBEEF);
    checks++; if ({lat[7:0], tok} !== {8'd3, 1'b1}) begin failures++; $display("FAIL wwr got lat=%0d tok=%b exp lat=3 tok=1", lat, tok); end
    checks++; if ({ram[0][12'h101], ram[0][12'h100]} !== 16'hBEEF) begin failures++; $display("FAIL wwr_ram got=%h%h exp=beef", ram[0][12'h101], ram[0][12'h100]); end
    issue(0, 1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, lat, rd, tok);
    ex = model_op(0, 1'b0, 1'b1, 16'h0100, 16'h0000);
    checks++; if (lat != 4) begin failures++; $display("FAIL wrd_lat got=%0d exp=4", lat); end
    checks++; if ({rd, tok} !== {16'hBEEF, 1'b1} || ex !== 16'hBEEF) begin failures++; $display("FAIL wrd_data got=%h/%b exp=beef/1", rd, tok); end
  endtask

  task automatic test_rom_vector();
    int lat; logic [15:0] rd, ex; bit tok;
    issue(0, 1'b1, 1'b0, 16'h0000, 16'h005A, 1'b0, lat, rd, tok);
    ex = model_op(0, 1'b1, 1'b0, 16'h0000, 16'h005A);
    issue(0, 1'b0, 1'b1, 16'hFFFC, 16'h0000, 1'b0, lat, rd, tok);
    ex = model_op(0, 1'b0, 1'b1, 16'hFFFC, 16'h0000);
    checks++; if ({rd, tok} !== {16'hF000, 1'b1}) begin failures++; $display("FAIL vec_fffc got=%h/%b exp=f000/1", rd, tok); end
    issue(0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, lat, rd, tok);
    ex = model_op(0, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    checks++; if ({rd, tok} !== {8'h5A, rom[4095], 1'b1} || ex[15:8] !== 8'h5A) begin failures++; $display("FAIL vec_wrap got=%h/%b exp=5a%h/1", rd, tok, rom[4095]); end
  endtask

  task automatic test_wait_states();
    int lat; logic [15:0] rd, ex; bit tok;
    issue(1, 1'b1, 1'b0, 16'h0020, 16'h003C, 1'b0, lat, rd, tok);
    ex = model_op(1, 1'b1, 1'b0, 16'h0020, 16'h003C);
    issue(1, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, lat, rd, tok);
    ex = model_op(1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    checks++; if (lat != 4) begin failures++; $display("FAIL ws_brd_lat got=%0d exp=4", lat); end
    checks++; if ({rd, tok} !== {16'h003C, 1'b1}) begin failures++; $display("FAIL ws_brd_data got=%h/%b exp=003c/1", rd, tok); end
    issue(1, 1'b1, 1'b1, 16'h0040, 16'h1357, 1'b1, lat, rd, tok);
    ex = model_op(1, 1'b1, 1'b1, 16'h0040, 16'h1357);
    checks++; if ({lat[7:0], tok} !== {8'd3, 1'b1}) begin failures++; $display("FAIL b2b_wr got lat=%0d tok=%b exp lat=3 tok=1", lat, tok); end
    issue(1, 1'b0, 1'b1, 16'h0040, 16'h0000, 1'b0, lat, rd, tok);
    ex = model_op(1, 1'b0, 1'b1, 16'h0040, 16'h0000);
    checks++; if (lat != 8) begin failures++; $display("FAIL b2b_wrd_lat got=%0d exp=8", lat); end
    checks++; if ({rd, tok} !== {16'h1357, 1'b1} || ex !== 16'h1357) begin failures++; $display("FAIL b2b_wrd_data got=%h/%b exp=1357/1", rd, tok); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [15:0] rd, ex; bit tok;
    issue(0, 1'b1, 1'b0, 16'h0201, 16'h0077, 1'b0, lat, rd, tok);
    ex = model_op(0, 1'b1, 1'b0, 16'h0201, 16'h0077);
    req_write[0] = 1'b1; req_word[0] = 1'b1; req_addr[0] = 16'h0200; req_wdata[0] = 16'hC3D4;
    req_valid[0] = 1'b1;
    @(posedge ph2); #1; req_valid[0] = 1'b0;
    @(posedge ph2); #1;
    @(posedge ph2); #1;
    checks++; if ({address[0], rws[0]} !== {16'h0201, 1'b0}) begin failures++; $display("FAIL abort_setup got=%h/%b exp=0201/0", address[0], rws[0]); end
    #2 rst[0] = 1'b0;
    #1;
    checks++; if ({rws[0], address[0], rsp_valid[0]} !== {1'b1, 16'hFFFF, 1'b0}) begin failures++; $display("FAIL abort_bus got=%b/%h/%b exp=1/ffff/0", rws[0], address[0], rsp_valid[0]); end
    mref[0][12'h200] = 8'hD4;
    repeat (2) @(posedge ph2);
    #1;
    checks++; if ({ram[0][12'h201], ram[0][12'h200]} !== 16'h77D4) begin failures++; $display("FAIL abort_ram got=%h%h exp=77d4", ram[0][12'h201], ram[0][12'h200]); end
    @(negedge ph2); rst[0] = 1'b1;
    #1;
    checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL abort_ready_early got=%b exp=0", req_ready[0]); end
    @(posedge ph2); #1;
    checks++; if ({req_ready[0], rsp_valid[0]} !== 2'b10) begin failures++; $display("FAIL abort_ready got=%b/%b exp=1/0", req_ready[0], rsp_valid[0]); end
  endtask

  task automatic test_unmapped();
    int lat; logic [15:0] rd, ex; bit tok;
    issue(0, 1'b1, 1'b0, 16'h2000, 16'h0099, 1'b0, lat, rd, tok);
    ex = model_op(0, 1'b1, 1'b0, 16'h2000, 16'h0099);
    issue(0, 1'b0, 1'b0, 16'h2000, 16'h0000, 1'b0, lat, rd, tok);
    ex = model_op(0, 1'b0, 1'b0, 16'h2000, 16'h0000);
    checks++; if ({rd, tok} !== {16'h0000, 1'b1}) begin failures++; $display("FAIL unmapped_rd got=%h/%b exp=0000/1", rd, tok); end
  endtask

  task automatic test_random();
    int lat, el, i, r; logic [15:0] rd, ex, a, d; bit tok, w, wd;
    for (int n = 0; n < 80; n++) begin
      i  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 7));
      if (r < 5)       a = 16'($urandom_range(0, 63));
      else if (r == 5) a = 16'($urandom_range(0, 4095));
      else if (r == 6) a = 16'hF000 | 16'($urandom_range(0, 4095));
      else             a = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0FFF;
      d = 16'($urandom);
      issue(i, w, wd, a, d, 1'b0, lat, rd, tok);
      ex = model_op(i, w, wd, a, d);
      el = exp_lat((i == 0) ? 0 : 2, w, wd);
      checks++; if (lat != el) begin failures++; $display("FAIL rnd_lat n=%0d dut=%0d got=%0d exp=%0d", n, i, lat, el); end
      checks++; if (rd !== ex) begin failures++; $display("FAIL rnd_data n=%0d dut=%0d a=%h got=%h exp=%h", n, i, a, rd, ex); end
      checks++; if (tok !== 1'b1) begin failures++; $display("FAIL rnd_bus n=%0d dut=%0d w=%b wd=%b a=%h got=0 exp=1", n, i, w, wd, a); end
    end
  endtask

  task automatic test_mem_compare();
    int bad;
    for (int i = 0; i < 2; i++) begin
      bad = 0;
      for (int j = 0; j < 4096; j++) if (ram[i][j] !== mref[i][j]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL ram_image[%0d] got=%0d differing bytes exp=0", i, bad); end
    end
  endtask

  initial begin
    for (int j = 0; j < 4096; j++) begin
      rom[j] = 8'($urandom);
      mref[0][j] = 8'h00;
      mref[1][j] = 8'h00;
    end
    rom[12'hFFC] = 8'h00;
    rom[12'hFFD] = 8'hF0;
    test_reset();
    test_byte_wr_rd();
    test_word();
    test_rom_vector();
    test_wait_states();
    test_reset_abort();
    test_unmapped();
    test_random();
    test_mem_compare();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete got=timeout exp=finish");
    $fatal(1);
  end

endmodule
